// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared AHB/APB bridge encodings, response states and default slave map
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic [1:0] {
        RS_OKAY = 2'b00,
        RS_ERR1 = 2'b01,
        RS_ERR2 = 2'b10
    } rstate_e;

    localparam logic [31:0] S0_BASE_DEF     = 32'h8000_0000;
    localparam logic [31:0] S1_BASE_DEF     = 32'h8400_0000;
    localparam logic [31:0] S2_BASE_DEF     = 32'h8800_0000;
    localparam int          REGION_BITS_DEF = 26;

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - one-hot APB slave select from the upper address bits
module apb_addr_decoder
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] S0_BASE     = S0_BASE_DEF,
    parameter logic [31:0] S1_BASE     = S1_BASE_DEF,
    parameter logic [31:0] S2_BASE     = S2_BASE_DEF,
    parameter int          REGION_BITS = REGION_BITS_DEF
) (
    input  logic [31-REGION_BITS:0] Haddr_region,
    output logic [2:0]              tempselx
);

    always_comb begin
        tempselx = 3'b000;
        // Priority order only matters if the bases are misconfigured to overlap
        if (Haddr_region == S0_BASE[31:REGION_BITS])
            tempselx = 3'b001;
        else if (Haddr_region == S1_BASE[31:REGION_BITS])
            tempselx = 3'b010;
        else if (Haddr_region == S2_BASE[31:REGION_BITS])
            tempselx = 3'b100;
    end

endmodule

// File: rtl/ahb_slave_interface.sv
// rtl/ahb_slave_interface.sv - AHB front end: transfer qualification, pipeline and ERROR response
module ahb_slave_interface
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] S0_BASE     = S0_BASE_DEF,
    parameter logic [31:0] S1_BASE     = S1_BASE_DEF,
    parameter logic [31:0] S2_BASE     = S2_BASE_DEF,
    parameter int          REGION_BITS = REGION_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [2:0]  Hsize,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    input  logic        Hreadyout_apb,
    output logic        valid,
    output logic [31:0] Haddr1,
    output logic [31:0] Haddr2,
    output logic [31:0] Hwdata1,
    output logic [31:0] Hwdata2,
    output logic        Hwritereg,
    output logic [2:0]  tempselx,
    output logic [31:0] Hrdata,
    output logic [1:0]  Hresp,
    output logic        Hreadyout
);

    logic [31:0] r_haddr1, r_haddr2, r_hwdata1, r_hwdata2;
    logic        r_hwritereg;
    rstate_e     r_rstate, w_rstate_next;
    logic        w_act, w_illegal;

    apb_addr_decoder #(
        .S0_BASE     (S0_BASE),
        .S1_BASE     (S1_BASE),
        .S2_BASE     (S2_BASE),
        .REGION_BITS (REGION_BITS)
    ) u_decoder (
        .Haddr_region (Haddr[31:REGION_BITS]),
        .tempselx     (tempselx)
    );

    assign w_act     = Hreadyin & ((Htrans == HTRANS_NONSEQ) | (Htrans == HTRANS_SEQ));
    assign w_illegal = (tempselx == 3'b000)
                     | (Hsize > 3'b010)
                     | ((Hsize == 3'b001) & Haddr[0])
                     | ((Hsize == 3'b010) & (Haddr[1:0] != 2'b00));
    assign valid     = w_act & ~w_illegal & (r_rstate != RS_ERR1);

    // Errored transfers are captured too; valid stays low so the FSM ignores them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_haddr1    <= '0;
            r_haddr2    <= '0;
            r_hwdata1   <= '0;
            r_hwdata2   <= '0;
            r_hwritereg <= 1'b0;
        end else if (Hreadyin) begin
            r_haddr1    <= Haddr;
            r_haddr2    <= r_haddr1;
            r_hwdata1   <= Hwdata;
            r_hwdata2   <= r_hwdata1;
            r_hwritereg <= Hwrite;
        end
    end

    assign Haddr1    = r_haddr1;
    assign Haddr2    = r_haddr2;
    assign Hwdata1   = r_hwdata1;
    assign Hwdata2   = r_hwdata2;
    assign Hwritereg = r_hwritereg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_rstate <= RS_OKAY;
        else
            r_rstate <= w_rstate_next;
    end

    always_comb begin
        w_rstate_next = r_rstate;
        Hreadyout     = Hreadyout_apb;
        Hresp         = HRESP_OKAY;
        Hrdata        = Prdata;
        case (r_rstate)
            RS_OKAY: begin
                if (w_act & w_illegal)
                    w_rstate_next = RS_ERR1;
            end
            RS_ERR1: begin
                w_rstate_next = RS_ERR2;
                Hreadyout     = 1'b0;
                Hresp         = HRESP_ERROR;
                Hrdata        = '0;
            end
            RS_ERR2: begin
                // A pending APB write may still be finishing; hold ERROR until it releases ready
                if (Hreadyout_apb)
                    w_rstate_next = RS_OKAY;
                Hresp  = HRESP_ERROR;
                Hrdata = '0;
            end
            default: w_rstate_next = RS_OKAY;
        endcase
    end

endmodule

// File: tb/tb_ahb_slave_interface.sv
// tb/tb_ahb_slave_interface.sv - directed table and sequence bench for ahb_slave_interface
module tb_ahb_slave_interface;

    logic        clk = 1'b0;
    logic        rst;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        Hreadyout_apb;
    logic        valid;
    logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2;
    logic        Hwritereg;
    logic [2:0]  tempselx;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;
    logic        Hreadyout;

    int checks = 0;
    int errors = 0;

    ahb_slave_interface dut (
        .clk           (clk),
        .rst           (rst),
        .Hwrite        (Hwrite),
        .Hreadyin      (Hreadyin),
        .Htrans        (Htrans),
        .Hsize         (Hsize),
        .Haddr         (Haddr),
        .Hwdata        (Hwdata),
        .Prdata        (Prdata),
        .Hreadyout_apb (Hreadyout_apb),
        .valid         (valid),
        .Haddr1        (Haddr1),
        .Haddr2        (Haddr2),
        .Hwdata1       (Hwdata1),
        .Hwdata2       (Hwdata2),
        .Hwritereg     (Hwritereg),
        .tempselx      (tempselx),
        .Hrdata        (Hrdata),
        .Hresp         (Hresp),
        .Hreadyout     (Hreadyout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        hreadyin;
        logic [1:0]  htrans;
        logic [2:0]  hsize;
        logic [31:0] haddr;
        logic        exp_valid;
        logic [2:0]  exp_sel;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b1, 2'b10, 3'b010, 32'h8000_0000, 1'b1, 3'b001, 1'b0};
        vecs[1]  = '{1'b1, 2'b11, 3'b010, 32'h8400_0004, 1'b1, 3'b010, 1'b0};
        vecs[2]  = '{1'b1, 2'b10, 3'b000, 32'h8800_0003, 1'b1, 3'b100, 1'b0};
        vecs[3]  = '{1'b1, 2'b10, 3'b001, 32'h8000_0001, 1'b0, 3'b001, 1'b1};
        vecs[4]  = '{1'b1, 2'b10, 3'b010, 32'h8000_0002, 1'b0, 3'b001, 1'b1};
        vecs[5]  = '{1'b1, 2'b10, 3'b011, 32'h8000_0000, 1'b0, 3'b001, 1'b1};
        vecs[6]  = '{1'b1, 2'b10, 3'b010, 32'h0000_0000, 1'b0, 3'b000, 1'b1};
        vecs[7]  = '{1'b1, 2'b00, 3'b010, 32'h0000_0000, 1'b0, 3'b000, 1'b0};
        vecs[8]  = '{1'b1, 2'b01, 3'b011, 32'h8000_0001, 1'b0, 3'b001, 1'b0};
        vecs[9]  = '{1'b1, 2'b10, 3'b001, 32'h8BFF_FFFE, 1'b1, 3'b100, 1'b0};
        vecs[10] = '{1'b1, 2'b10, 3'b010, 32'h8C00_0000, 1'b0, 3'b000, 1'b1};
        vecs[11] = '{1'b0, 2'b10, 3'b011, 32'h0000_0001, 1'b0, 3'b000, 1'b0};

        // Reset held with a legal NONSEQ on the bus
        rst = 1'b0; Hwrite = 1'b1; Hreadyin = 1'b1; Htrans = 2'b10; Hsize = 3'b010;
        Haddr = 32'h8000_0000; Hwdata = 32'hFFFF_FFFF; Prdata = 32'hA5A5_0001; Hreadyout_apb = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_haddr1", Haddr1, 32'h0);
        check("rst_haddr2", Haddr2, 32'h0);
        check("rst_hwdata1", Hwdata1, 32'h0);
        check("rst_hwdata2", Hwdata2, 32'h0);
        check("rst_hwritereg", {31'h0, Hwritereg}, 32'h0);
        check("rst_hresp", {30'h0, Hresp}, 32'h0);
        check("rst_hreadyout", {31'h0, Hreadyout}, 32'h1);
        check("rst_hrdata", Hrdata, 32'hA5A5_0001);
        rst = 1'b1;
        #2;
        check("post_rst_valid", {31'h0, valid}, 32'h1);
        check("post_rst_sel", {29'h0, tempselx}, 32'h1);

        // Table: combinational decode, then the response after one clock; reset returns to OKAY
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            Hreadyin = vecs[i].hreadyin; Htrans = vecs[i].htrans;
            Hsize = vecs[i].hsize; Haddr = vecs[i].haddr;
            #2;
            check($sformatf("v%0d_valid", i), {31'h0, valid}, {31'h0, vecs[i].exp_valid});
            check($sformatf("v%0d_sel", i), {29'h0, tempselx}, {29'h0, vecs[i].exp_sel});
            check($sformatf("v%0d_hresp0", i), {30'h0, Hresp}, 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_hresp1", i), {30'h0, Hresp}, vecs[i].exp_err ? 32'h1 : 32'h0);
            check($sformatf("v%0d_ready1", i), {31'h0, Hreadyout}, vecs[i].exp_err ? 32'h0 : 32'h1);
            rst = 1'b0; #1; rst = 1'b1;
        end

        // Write pipeline
        @(negedge clk);
        Hreadyin = 1'b1; Htrans = 2'b10; Hsize = 3'b010; Hwrite = 1'b1;
        Haddr = 32'h8400_0010; Hwdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("wr_haddr1", Haddr1, 32'h8400_0010);
        check("wr_hwdata1", Hwdata1, 32'hDEAD_BEEF);
        check("wr_hwritereg", {31'h0, Hwritereg}, 32'h1);
        Haddr = 32'h8400_0014; Hwdata = 32'h0BAD_F00D; Hwrite = 1'b0;
        @(negedge clk);
        check("wr_haddr2", Haddr2, 32'h8400_0010);
        check("wr_hwdata2", Hwdata2, 32'hDEAD_BEEF);
        check("wr_haddr1_b", Haddr1, 32'h8400_0014);
        check("wr_hwdata1_b", Hwdata1, 32'h0BAD_F00D);
        check("wr_hwritereg_b", {31'h0, Hwritereg}, 32'h0);

        // Read from slave 2
        Haddr = 32'h8800_0004; Prdata = 32'h1234_5678;
        #2;
        check("rd_sel", {29'h0, tempselx}, 32'h4);
        check("rd_hrdata", Hrdata, 32'h1234_5678);
        check("rd_hresp", {30'h0, Hresp}, 32'h0);
        check("rd_valid", {31'h0, valid}, 32'h1);

        // Unmapped address: two-cycle ERROR then OKAY
        @(negedge clk);
        Haddr = 32'h0000_0000;
        #2;
        check("err_valid", {31'h0, valid}, 32'h0);
        @(negedge clk);
        Htrans = 2'b00;
        check("err1_hresp", {30'h0, Hresp}, 32'h1);
        check("err1_ready", {31'h0, Hreadyout}, 32'h0);
        check("err1_hrdata", Hrdata, 32'h0);
        @(negedge clk);
        check("err2_hresp", {30'h0, Hresp}, 32'h1);
        check("err2_ready", {31'h0, Hreadyout}, 32'h1);
        @(negedge clk);
        check("err_done_hresp", {30'h0, Hresp}, 32'h0);
        check("err_done_hrdata", Hrdata, 32'h1234_5678);

        // Misaligned word while the APB side is stalled
        Htrans = 2'b10; Hsize = 3'b010; Haddr = 32'h8000_0002; Hreadyout_apb = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            Htrans = 2'b00;
            check($sformatf("ws%0d_hresp", c), {30'h0, Hresp}, 32'h1);
            check($sformatf("ws%0d_ready", c), {31'h0, Hreadyout}, 32'h0);
        end
        Hreadyout_apb = 1'b1;
        #1;
        check("ws_release_ready", {31'h0, Hreadyout}, 32'h1);
        check("ws_release_hresp", {30'h0, Hresp}, 32'h1);
        @(negedge clk);
        check("ws_done_hresp", {30'h0, Hresp}, 32'h0);

        // Hreadyin low holds the pipeline
        Hreadyin = 1'b1; Htrans = 2'b10; Haddr = 32'h8000_0100; Hwrite = 1'b1; Hwdata = 32'h1111_1111;
        @(negedge clk);
        Haddr = 32'h8000_0200; Hwdata = 32'h2222_2222;
        @(negedge clk);
        Hreadyin = 1'b0;
        for (int c = 0; c < 4; c++) begin
            Haddr = 32'h8400_0000 + 32'(c * 4); Hwdata = 32'(c); Hwrite = 1'b0;
            @(negedge clk);
        end
        check("hold_haddr1", Haddr1, 32'h8000_0200);
        check("hold_haddr2", Haddr2, 32'h8000_0100);
        check("hold_hwdata2", Hwdata2, 32'h1111_1111);
        check("hold_hwritereg", {31'h0, Hwritereg}, 32'h1);

        // Asynchronous reset mid-cycle, both pipeline and an active ERROR
        Hreadyin = 1'b1; Htrans = 2'b10; Haddr = 32'h0000_0000;
        @(posedge clk);
        #2;
        check("pre_arst_hresp", {30'h0, Hresp}, 32'h1);
        rst = 1'b0;
        #1;
        check("arst_haddr1", Haddr1, 32'h0);
        check("arst_haddr2", Haddr2, 32'h0);
        check("arst_hwdata1", Hwdata1, 32'h0);
        check("arst_hresp", {30'h0, Hresp}, 32'h0);
        check("arst_ready", {31'h0, Hreadyout}, 32'h1);
        rst = 1'b1;

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_slave_interface.md
# ahb_slave_interface

AHB-side front end of the AHB-to-APB bridge, directly upstream of the APB bridge FSM. It qualifies AHB transfers and pipelines address, write data and direction into the registers the FSM consumes (`Haddr1/Haddr2`, `Hwdata1/Hwdata2`, `Hwritereg`). It also decodes the APB slave select and returns read data to the AHB master. A small response FSM generates the two-cycle AHB ERROR response for unmapped or illegal transfers.

## Interface
- `S0_BASE`, default 32'h8000_0000: base address of APB slave 0.
- `S1_BASE`, default 32'h8400_0000: base address of APB slave 1.
- `S2_BASE`, default 32'h8800_0000: base address of APB slave 2.
- `REGION_BITS`, default 26: region size is 2^REGION_BITS bytes; the region is matched on `Haddr[31:REGION_BITS]`.
- `clk  in  1`: single clock; all state updates on its rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `Hwrite  in  1`: AHB direction; 1 = write.
- `Hreadyin  in  1`: AHB bus ready; the address phase is accepted when it is 1.
- `Htrans  in  2`: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `Hsize  in  3`: transfer size.
- `Haddr  in  32`: AHB address.
- `Hwdata  in  32`: AHB write data.
- `Prdata  in  32`: APB read data.
- `Hreadyout_apb  in  1`: `Hreadyout` from the APB FSM.
- `valid  out  1`: qualified, legal transfer in the current address phase.
- `Haddr1`, `Haddr2  out  32`: address pipeline stages 1 and 2.
- `Hwdata1`, `Hwdata2  out  32`: write-data pipeline stages 1 and 2.
- `Hwritereg  out  1`: registered `Hwrite`.
- `tempselx  out  3`: one-hot slave select decoded from `Haddr`.
- `Hrdata  out  32`: read data to the master.
- `Hresp  out  2`: 00 OKAY, 01 ERROR.
- `Hreadyout  out  1`: ready to the master.

## Operation
- `act = Hreadyin & Htrans[1]`, i.e. a NONSEQ or SEQ transfer being accepted.
- Slave decode:
  - 3'b001 when `Haddr[31:REGION_BITS] == S0_BASE[31:REGION_BITS]`.
  - 3'b010 for S1, 3'b100 for S2.
  - Otherwise 000.
- Illegal transfer, any of:
  - `tempselx == 0`;
  - `Hsize > 3'b010`;
  - `Hsize == 3'b001` and `Haddr[0]`;
  - `Hsize == 3'b010` and `Haddr[1:0] != 0`.
- `valid = act & ~illegal & (rstate != ERR1)`. It is combinational.
- Pipeline, on each cycle with `Hreadyin = 1`:
  - `Haddr1 <= Haddr`, `Haddr2 <= Haddr1`;
  - `Hwdata1 <= Hwdata`, `Hwdata2 <= Hwdata1`;
  - `Hwritereg <= Hwrite`.
  - All hold while `Hreadyin = 0`.
  - Errored transfers are still captured; this is harmless because `valid` stays 0.
- Response FSM `rstate`:
  - OKAY → ERR1 when `act & illegal`; otherwise stays in OKAY.
  - ERR1 → ERR2 unconditionally.
  - ERR2 → OKAY when `Hreadyout_apb = 1`; otherwise stays in ERR2.
- Outputs per state:
  - OKAY: `Hreadyout = Hreadyout_apb`, `Hresp = 00`.
  - ERR1: `Hreadyout = 0`, `Hresp = 01`.
  - ERR2: `Hreadyout = Hreadyout_apb`, `Hresp = 01`.
- In ERR2 a pending APB write may still be completing. ERROR is held until the FSM releases ready, so the response completes legally.
- `Hrdata = Prdata` in OKAY; 32'h0 in ERR1 and ERR2.
- A transfer presented in the final ERR2 cycle with `Hreadyin = 1` is a new address phase and is handled normally (a master may also drive IDLE there).
- BUSY and IDLE transfers: `valid = 0`, no error, response OKAY.

## Timing
- Reset (rst = 0, asynchronous):
  - All pipeline registers 0; `rstate = OKAY`.
  - Combinational outputs are then `Hresp = 00`, `Hreadyout = Hreadyout_apb`, `Hrdata = Prdata`.
- Reset asserted mid-transfer clears state immediately, with no waiting for the clock edge.
- Pipeline latency: 1 cycle to `Haddr1/Hwdata1/Hwritereg`, 2 cycles to `Haddr2/Hwdata2`.
- `valid` and `tempselx` are zero-latency, decoded in the same cycle as `Haddr`/`Htrans`.
- ERROR response:
  - `Hresp = 01` is first visible the cycle after the illegal address phase.
  - Minimum response is 2 cycles: low ready, then high ready.
- `Hreadyin` is externally tied to `Hreadyout` at the bridge top.

## Structure
- Shared package `ahb_apb_pkg` holds:
  - `Htrans` encodings (IDLE, BUSY, NONSEQ, SEQ);
  - `Hresp` encodings (OKAY, ERROR);
  - the `rstate` enum (OKAY, ERR1, ERR2);
  - default slave base addresses.
- One natural sub-module: `apb_addr_decoder`, combinational `Haddr` → `tempselx`, parameterised by bases and `REGION_BITS`.

## Test plan
- Reset with `Haddr = 32'h8000_0000` and `Htrans = 10` held → all registers 0, `Hresp = 00`; after release `valid = 1`, `tempselx = 001`.
- Write NONSEQ to 32'h8400_0010, data 32'hDEAD_BEEF, `Hreadyin = 1` → `Haddr1 = 32'h8400_0010` after 1 cycle; `Hwdata2 = 32'hDEAD_BEEF` and `Haddr2 = 32'h8400_0010` after 2 cycles; `Hwritereg = 1`.
- Read from 32'h8800_0004 with `Prdata = 32'h1234_5678` → `tempselx = 100`, `Hrdata = 32'h1234_5678`, `Hresp = 00`.
- NONSEQ to 32'h0000_0000 → `valid = 0`; next cycle `Hresp = 01`, `Hreadyout = 0`; following cycle `Hresp = 01`, `Hreadyout = 1`; then OKAY.
- Word (`Hsize = 010`) to 32'h8000_0002 while `Hreadyout_apb = 0` for 3 cycles → ERROR held with `Hreadyout = 0` until `Hreadyout_apb = 1`.
- `Hreadyin = 0` for 4 cycles with changing `Haddr` → `Haddr1`/`Haddr2` unchanged; `rst` pulsed low mid-cycle → outputs clear before the next clock edge.
